// File: rtl/apb_reg_pkg.sv
// Shared types and constants for the APB register bank.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package apb_reg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Bit of the last register that acts as the write lock
    localparam int LOCK_BIT = 0;

    // Byte address to word index shift
    localparam int ADDR_OFS = 2;

    // Width of a counter able to hold 0..w
    function automatic int wait_cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/apb_reg_bank_fsm.sv
// APB slave handshake: SETUP/ACCESS sequencing, wait counter, PREADY/PSLVERR.
// Latency: PREADY registered, high 2 + WAIT cycles after entering SETUP.
// Backpressure: PREADY held low for WAIT access cycles; PSEL drop in ACCESS aborts.
module apb_reg_bank_fsm
    import apb_reg_pkg::*;
#(
    parameter int WAIT = 0
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic PSEL,
    input  logic PENABLE,
    input  logic err,
    output logic start,
    output logic done,
    output logic PREADY,
    output logic PSLVERR
);

    localparam int CW = wait_cnt_w(WAIT);

    apb_state_t      state;
    logic [CW-1:0]   wcnt;
    logic [CW-1:0]   wcnt_inc;

    // Saturating increment of the wait counter
    always_comb begin
        wcnt_inc = (wcnt == CW'(WAIT)) ? wcnt : wcnt + CW'(1);
    end

    // start: a setup phase is seen this cycle; done: PREADY rises at the next edge
    always_comb begin
        start = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE:    start = PSEL & ~PENABLE;
            SETUP:   done  = PSEL & PENABLE & (WAIT == 0);
            ACCESS: begin
                start = PREADY & PSEL & ~PENABLE;
                done  = ~PREADY & PSEL & (wcnt_inc == CW'(WAIT));
            end
            default: ;
        endcase
    end

    // Handshake state, wait counter and registered response flags
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            wcnt    <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
        end else begin
            PREADY  <= done;
            PSLVERR <= done & err;
            case (state)
                IDLE: begin
                    if (start) state <= SETUP;
                end
                SETUP: begin
                    wcnt  <= '0;
                    // missing PENABLE after setup is a protocol error: drop the transfer
                    state <= (PSEL && PENABLE) ? ACCESS : IDLE;
                end
                ACCESS: begin
                    if (PREADY || !PSEL) begin
                        wcnt  <= '0;
                        state <= start ? SETUP : IDLE;
                    end else begin
                        wcnt  <= wcnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/apb_reg_bank.sv
// APB3 register bank: NUM byte-strobed registers, RO status slots, optional lock (APB_REG_BANK_LOCK_EN).
// Latency: 2 + WAIT cycles setup-to-PREADY; writes visible on reg_q the cycle after PREADY.
// Backpressure: WAIT wait states per transfer; errors answered with PSLVERR, never stalled.
module apb_reg_bank
    import apb_reg_pkg::*;
#(
    parameter int             DW      = 32,
    parameter int             AW      = 16,
    parameter int             NUM     = 8,
    parameter int             WAIT    = 0,
    parameter logic [NUM-1:0] RO_MASK = '0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [AW-1:0]     PADDR,
    input  logic [DW-1:0]     PWDATA,
    input  logic [DW/8-1:0]   PSTRB,
    output logic [DW-1:0]     PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [NUM*DW-1:0] hw_status,
    output logic [NUM*DW-1:0] reg_q
);

    localparam int IW = $clog2(NUM);
    localparam int SW = AW - ADDR_OFS;
    localparam int NB = DW / 8;

`ifdef APB_REG_BANK_LOCK_EN
    // The lock register is always writable
    localparam logic [NUM-1:0] RO_EFF = RO_MASK & {1'b0, {(NUM-1){1'b1}}};
`else
    localparam logic [NUM-1:0] RO_EFF = RO_MASK;
`endif

    logic [DW-1:0] regs [NUM];
    logic [SW-1:0] word_idx;
    logic          dec_err;
    logic [IW-1:0] slot_q;
    logic          wr_q;
    logic          aerr_q;
    logic          ro_hit;
    logic          lock_err;
    logic          acc_err;
    logic          start;
    logic          done;
    logic          commit;

    assign word_idx = PADDR[AW-1:ADDR_OFS];
    assign dec_err  = (32'(word_idx) >= 32'(NUM)) || (PADDR[ADDR_OFS-1:0] != '0);
    assign ro_hit   = RO_EFF[slot_q];

`ifdef APB_REG_BANK_LOCK_EN
    assign lock_err = regs[NUM-1][LOCK_BIT] & (slot_q != IW'(NUM-1));
`else
    assign lock_err = 1'b0;
`endif

    assign acc_err = aerr_q | (wr_q & (ro_hit | lock_err));
    assign commit  = PREADY & wr_q & ~PSLVERR;

    apb_reg_bank_fsm #(
        .WAIT (WAIT)
    ) u_fsm (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .err     (acc_err),
        .start   (start),
        .done    (done),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    // Capture address decode and direction from the bus setup phase
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            slot_q <= '0;
            wr_q   <= 1'b0;
            aerr_q <= 1'b0;
        end else if (start) begin
            slot_q <= word_idx[IW-1:0];
            wr_q   <= PWRITE;
            aerr_q <= dec_err;
        end
    end

    // Byte-lane write into storage at the end of an error-free PREADY cycle
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int b = 0; b < NB; b++) begin
                if (PSTRB[b]) regs[slot_q][8*b +: 8] <= PWDATA[8*b +: 8];
            end
`ifdef APB_REG_BANK_LOCK_EN
            // lock is sticky until reset
            if (regs[NUM-1][LOCK_BIT]) regs[NUM-1][LOCK_BIT] <= 1'b1;
`endif
        end
    end

    // Read data loaded together with PREADY, held between transfers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PRDATA <= '0;
        end else if (done && !wr_q) begin
            if (acc_err)     PRDATA <= '0;
            else if (ro_hit) PRDATA <= hw_status[int'(slot_q)*DW +: DW];
            else             PRDATA <= regs[slot_q];
        end
    end

    // Status slots show zero on the register image
    for (genvar i = 0; i < NUM; i++) begin : g_regq
        assign reg_q[i*DW +: DW] = RO_EFF[i] ? '0 : regs[i];
    end

endmodule
